rv32v_memory_arbiter: RTL



---
 rtl/rv32v_memory_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/rv32v_memory_arbiter.sv
// rv32v_memory_arbiter: age-ordered arbiter for the shared data-memory port between the scalar pipeline and the vector LSU.
// Optional starvation guard enabled by defining RV32V_MEM_ARB_FAIRNESS_EN.
module rv32v_memory_arbiter #(
    parameter int NUM_CB_ENTRY = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [$clog2(NUM_CB_ENTRY)-1:0] cb_tail_index,
    input  logic [$clog2(NUM_CB_ENTRY)-1:0] scalar_cb_index,
    input  logic [$clog2(NUM_CB_ENTRY)-1:0] vector_cb_index,
    input  logic                            s_ren,
    input  logic                            s_wen,
    input  logic [31:0]                     s_addr,
    input  logic [31:0]                     s_wdata,
    input  logic [3:0]                      s_byte_en,
    output logic [31:0]                     s_rdata,
    output logic                            s_busy,
    input  logic                            v_ren,
    input  logic                            v_wen,
    input  logic [31:0]                     v_addr,
    input  logic [31:0]                     v_wdata,
    input  logic [3:0]                      v_byte_en,
    output logic [31:0]                     v_rdata,
    output logic                            v_busy,
    output logic                            mem_ren,
    output logic                            mem_wen,
    output logic [31:0]                     mem_addr,
    output logic [31:0]                     mem_wdata,
    output logic [3:0]                      mem_byte_en,
    input  logic [31:0]                     mem_rdata,
    input  logic                            mem_busy
);
    localparam int W = $clog2(NUM_CB_ENTRY);
    typedef enum logic [1:0] {IDLE, GRANT_S, GRANT_V} state_e;
    state_e state_q, state_d;
    logic [W-1:0] age_s, age_v;
    logic s_req, v_req, v_wins, grant_s, grant_v, s_act, v_act, strobe, done;
    assign s_req   = s_ren | s_wen;
    assign v_req   = v_ren | v_wen;
    assign age_s   = scalar_cb_index - cb_tail_index;
    assign age_v   = vector_cb_index - cb_tail_index;
    assign grant_v = v_req && (!s_req || v_wins);
    assign grant_s = s_req && !grant_v;
`ifdef RV32V_MEM_ARB_FAIRNESS_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] s_cnt_q, v_cnt_q;
    logic s_sat, v_sat;
    assign s_sat  = s_cnt_q == CW'(STARVE_LIMIT);
    assign v_sat  = v_cnt_q == CW'(STARVE_LIMIT);
    assign v_wins = !s_sat && (v_sat || age_v < age_s);
    // Loss counters: a requester losing in IDLE counts up (saturating), its own grant clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            s_cnt_q <= grant_s ? '0 : (s_req && !s_sat) ? s_cnt_q + 1'b1 : s_cnt_q;
            v_cnt_q <= grant_v ? '0 : (v_req && !v_sat) ? v_cnt_q + 1'b1 : v_cnt_q;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = |STARVE_LIMIT;
    assign v_wins = age_v < age_s;
`endif
    assign s_act       = state_q == GRANT_S;
    assign v_act       = state_q == GRANT_V;
    assign mem_wen     = s_act ? s_wen : v_act ? v_wen : 1'b0;
    assign mem_ren     = (s_act ? s_ren : v_act ? v_ren : 1'b0) & ~mem_wen;
    assign mem_addr    = s_act ? s_addr : v_act ? v_addr : 32'd0;
    assign mem_wdata   = s_act ? s_wdata : v_act ? v_wdata : 32'd0;
    assign mem_byte_en = s_act ? s_byte_en : v_act ? v_byte_en : 4'd0;
    assign strobe      = mem_ren | mem_wen;
    assign done        = strobe & ~mem_busy;
    assign s_busy      = !(s_act && done);
    assign v_busy      = !(v_act && done);
    assign s_rdata     = (s_act && done) ? mem_rdata : 32'd0;
    assign v_rdata     = (v_act && done) ? mem_rdata : 32'd0;
    // Next state: arbitrate in IDLE; leave a grant on completion or when the requester withdraws.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = grant_s ? GRANT_S : grant_v ? GRANT_V : IDLE;
        else if (!(strobe && mem_busy))
            state_d = IDLE;
    end
    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end
endmodule
